// File: rtl/dma_s2mm_writer.sv
// Stream-to-memory DMA channel: writes each accepted AXI-stream beat into
// consecutive line-SRAM words starting at a commanded base address.
module dma_s2mm_writer #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 9,
    parameter int LEN_W  = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [ADDR_W-1:0] cmd_base_i,
    input  logic [LEN_W-1:0]  cmd_len_i,
    input  logic              abort_i,
    input  logic [DATA_W-1:0] s_tdata_i,
    input  logic              s_tvalid_i,
    input  logic              s_tlast_i,
    output logic              s_tready_o,
    output logic              mem_wr_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    typedef enum logic [1:0] {IDLE, RECV, DRAIN, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] base_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  count;
    logic              beat;
    logic              cmd_accept;
    logic              final_beat;

    // Handshake outputs decode straight from the state register.
    assign cmd_ready_o = (state == IDLE);
    assign s_tready_o  = (state == RECV) || (state == DRAIN);
    assign busy_o      = (state != IDLE);
    assign done_o      = (state == DONE);

    assign beat       = s_tvalid_i & s_tready_o;
    assign cmd_accept = cmd_valid_i & cmd_ready_o;
    assign final_beat = (count == len_q - LEN_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            base_q     <= '0;
            len_q      <= '0;
            count      <= '0;
            mem_wr_o   <= 1'b0;
            mem_addr_o <= '0;
            mem_data_o <= '0;
            err_o      <= 1'b0;
        end else begin
            mem_wr_o <= 1'b0;
            // A beat taken in RECV is always written, even alongside an abort.
            if (state == RECV && beat) begin
                mem_wr_o   <= 1'b1;
                mem_addr_o <= base_q + ADDR_W'(count);
                mem_data_o <= s_tdata_i;
                count      <= count + LEN_W'(1);
            end
            if (abort_i) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (cmd_accept) begin
                            base_q <= cmd_base_i;
                            len_q  <= cmd_len_i;
                            count  <= '0;
                            err_o  <= 1'b0;
                            state  <= (cmd_len_i != '0) ? RECV : DONE;
                        end
                    end
                    RECV: begin
                        if (beat) begin
                            if (final_beat) begin
                                if (s_tlast_i) begin
                                    state <= DONE;
                                end else begin
                                    err_o <= 1'b1;
                                    state <= DRAIN;
                                end
                            end else if (s_tlast_i) begin
                                err_o <= 1'b1;
                                state <= DONE;
                            end
                        end
                    end
                    DRAIN: begin
                        if (beat && s_tlast_i) begin
                            state <= DONE;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dma_s2mm_writer.sv
// Randomized bench for dma_s2mm_writer: every transfer's expected SRAM writes,
// done timing and error flag are derived from the command and the beats sent.
module tb_dma_s2mm_writer;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [8:0]  cmd_base;
    logic [8:0]  cmd_len;
    logic        abort;
    logic [63:0] tdata;
    logic        tvalid;
    logic        tlast;
    logic        tready;
    logic        mem_wr;
    logic [8:0]  mem_addr;
    logic [63:0] mem_data;
    logic        busy;
    logic        done;
    logic        err;

    int vectors;
    int miscompares;

    dma_s2mm_writer #(.DATA_W(64), .ADDR_W(9), .LEN_W(9)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_base_i(cmd_base), .cmd_len_i(cmd_len), .abort_i(abort),
        .s_tdata_i(tdata), .s_tvalid_i(tvalid), .s_tlast_i(tlast), .s_tready_o(tready),
        .mem_wr_o(mem_wr), .mem_addr_o(mem_addr), .mem_data_o(mem_data),
        .busy_o(busy), .done_o(done), .err_o(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observation log, sampled on the falling edge away from the active edge.
    int          cyc;
    logic [8:0]  wr_addr_q[$];
    logic [63:0] wr_data_q[$];
    int          wr_cyc_q[$];
    int          beat_cyc_q[$];
    int          acc_cyc_q[$];
    int          done_cyc_q[$];
    bit          tready_seen;
    bit          done_prev;
    bit          ready_after_done;

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (mem_wr) begin
                wr_addr_q.push_back(mem_addr);
                wr_data_q.push_back(mem_data);
                wr_cyc_q.push_back(cyc);
            end
            if (tvalid && tready) beat_cyc_q.push_back(cyc);
            if (cmd_valid && cmd_ready) acc_cyc_q.push_back(cyc);
            if (done) done_cyc_q.push_back(cyc);
            if (tready) tready_seen = 1'b1;
            if (done_prev) ready_after_done = cmd_ready;
            done_prev = done;
        end
    end

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        beat_cyc_q.delete();
        acc_cyc_q.delete();
        done_cyc_q.delete();
        tready_seen      = 1'b0;
        ready_after_done = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while (!cmd_ready && t < 50) begin
            tick();
            t++;
        end
        vectors++;
        if (!cmd_ready) begin
            miscompares++;
            $display("[TB] FAIL %s idle_timeout: cmd_ready got %b expected 1", name, cmd_ready);
        end
    endtask

    task automatic issue_cmd(input string name, input logic [8:0] base, input int len);
        wait_idle(name);
        cmd_base  = base;
        cmd_len   = 9'(len);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        vectors++;
        if (acc_cyc_q.size() !== 1) begin
            miscompares++;
            $display("[TB] FAIL %s cmd_accept: got %0d accepts expected 1", name, acc_cyc_q.size());
        end
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL %s err_clear_on_accept: got %b expected 0", name, err);
        end
    endtask

    task automatic send_beat(input logic [63:0] d, input logic last, input int max_gap, input logic with_abort);
        int gaps = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        repeat (gaps) tick();
        tdata  = d;
        tlast  = last;
        tvalid = 1'b1;
        abort  = with_abort;
        tick();
        tvalid = 1'b0;
        tlast  = 1'b0;
        abort  = 1'b0;
    endtask

    // Compare logged writes with the model: beat i lands at (base+i) mod 512.
    task automatic check_writes(input string name, input logic [8:0] base,
                                input logic [63:0] sent[$], input int nwr);
        int n;
        vectors++;
        if (wr_addr_q.size() !== nwr) begin
            miscompares++;
            $display("[TB] FAIL %s write_count: got %0d expected %0d", name, wr_addr_q.size(), nwr);
        end
        n = nwr;
        if (wr_addr_q.size() < n) n = wr_addr_q.size();
        if (beat_cyc_q.size() < n) n = beat_cyc_q.size();
        for (int i = 0; i < n; i++) begin
            logic [8:0] exp_addr = 9'((int'(base) + i) % 512);
            vectors++;
            if (wr_addr_q[i] !== exp_addr) begin
                miscompares++;
                $display("[TB] FAIL %s wr_addr[%0d]: got %h expected %h", name, i, wr_addr_q[i], exp_addr);
            end
            vectors++;
            if (wr_data_q[i] !== sent[i]) begin
                miscompares++;
                $display("[TB] FAIL %s wr_data[%0d]: got %h expected %h", name, i, wr_data_q[i], sent[i]);
            end
            vectors++;
            if (wr_cyc_q[i] !== beat_cyc_q[i] + 1) begin
                miscompares++;
                $display("[TB] FAIL %s wr_latency[%0d]: got cycle %0d expected %0d", name, i, wr_cyc_q[i], beat_cyc_q[i] + 1);
            end
        end
    endtask

    // One complete transfer: nbeats sent with tlast on the last one.
    task automatic run_xfer(input string name, input logic [8:0] base, input int len,
                            input int nbeats, input int max_gap);
        logic [63:0] sent[$];
        int  nwr;
        int  exp_done;
        bit  exp_err;
        clear_log();
        issue_cmd(name, base, len);
        if (len != 0) begin
            for (int i = 0; i < nbeats; i++) begin
                logic [63:0] d = {$urandom(), $urandom()};
                sent.push_back(d);
                send_beat(d, (i == nbeats - 1), max_gap, 1'b0);
            end
        end
        repeat (4) tick();
        nwr     = (len == 0) ? 0 : ((nbeats < len) ? nbeats : len);
        exp_err = (len != 0) && (nbeats != len);
        check_writes(name, base, sent, nwr);
        vectors++;
        if (beat_cyc_q.size() !== ((len == 0) ? 0 : nbeats)) begin
            miscompares++;
            $display("[TB] FAIL %s beat_count: got %0d expected %0d", name, beat_cyc_q.size(), (len == 0) ? 0 : nbeats);
        end
        vectors++;
        if (done_cyc_q.size() !== 1) begin
            miscompares++;
            $display("[TB] FAIL %s done_count: got %0d expected 1", name, done_cyc_q.size());
        end else begin
            if (len == 0) exp_done = (acc_cyc_q.size() > 0) ? acc_cyc_q[0] + 1 : -1;
            else          exp_done = (beat_cyc_q.size() > 0) ? beat_cyc_q[beat_cyc_q.size() - 1] + 1 : -1;
            vectors++;
            if (done_cyc_q[0] !== exp_done) begin
                miscompares++;
                $display("[TB] FAIL %s done_cycle: got %0d expected %0d", name, done_cyc_q[0], exp_done);
            end
        end
        vectors++;
        if (err !== exp_err) begin
            miscompares++;
            $display("[TB] FAIL %s err: got %b expected %b", name, err, exp_err);
        end
        vectors++;
        if (ready_after_done !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL %s ready_after_done: got %b expected 1", name, ready_after_done);
        end
        if (len == 0) begin
            vectors++;
            if (tready_seen !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL %s tready_on_empty: got %b expected 0", name, tready_seen);
            end
        end
    endtask

    task automatic check_reset_values(input string name);
        logic [79:0] got;
        logic [79:0] exp;
        got = {cmd_ready, tready, mem_wr, busy, done, err, mem_addr, mem_data};
        exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 64'h0};
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s reset_outputs: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check_reset_values("test_reset");
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        run_xfer("test_basic", 9'h010, 4, 4, 0);
    endtask

    task automatic test_wrap();
        run_xfer("test_wrap", 9'h1FE, 4, 4, 1);
    endtask

    task automatic test_short();
        run_xfer("test_short", 9'h040, 4, 2, 0);
    endtask

    task automatic test_long();
        run_xfer("test_long", 9'h080, 2, 5, 1);
    endtask

    task automatic test_empty();
        run_xfer("test_empty", 9'h0C0, 0, 0, 0);
        run_xfer("test_empty_pre", 9'h0C8, 3, 1, 0);
        run_xfer("test_empty_clear", 9'h0D0, 0, 0, 0);
    endtask

    // Abort after three beats; the third beat either precedes or shares the abort cycle.
    task automatic test_abort(input bit abort_with_beat);
        string       name = abort_with_beat ? "test_abort_same" : "test_abort_after";
        logic [8:0]  base = 9'($urandom());
        logic [63:0] sent[$];
        clear_log();
        issue_cmd(name, base, 8);
        for (int i = 0; i < 3; i++) begin
            logic [63:0] d = {$urandom(), $urandom()};
            sent.push_back(d);
            send_beat(d, 1'b0, 2, abort_with_beat && (i == 2));
        end
        if (!abort_with_beat) begin
            abort = 1'b1;
            tick();
            abort = 1'b0;
        end
        vectors++;
        if ({busy, cmd_ready, tready} !== 3'b010) begin
            miscompares++;
            $display("[TB] FAIL %s idle_after_abort: got busy/ready/tready %b expected 010", name, {busy, cmd_ready, tready});
        end
        repeat (4) tick();
        check_writes(name, base, sent, 3);
        vectors++;
        if (done_cyc_q.size() !== 0) begin
            miscompares++;
            $display("[TB] FAIL %s done_on_abort: got %0d pulses expected 0", name, done_cyc_q.size());
        end
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL %s err_after_abort: got %b expected 0", name, err);
        end
    endtask

    // Reset while draining with err set and a non-zero write address held.
    task automatic test_reset_mid();
        clear_log();
        issue_cmd("test_reset_mid", 9'h0A5, 2);
        for (int i = 0; i < 4; i++) send_beat({$urandom(), $urandom()}, 1'b0, 0, 1'b0);
        vectors++;
        if ({busy, err} !== 2'b11) begin
            miscompares++;
            $display("[TB] FAIL test_reset_mid pre_reset: got busy/err %b expected 11", {busy, err});
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("test_reset_mid");
        tick();
        rst_n = 1'b1;
        tick();
        run_xfer("test_reset_recover", 9'h033, 3, 3, 1);
    endtask

    task automatic test_random_back_to_back();
        for (int k = 0; k < 10; k++) begin
            logic [8:0] base = 9'($urandom());
            int len  = $urandom_range(12, 1);
            int mode = $urandom_range(2, 0);
            int nb   = (mode == 0) ? len : (mode == 1) ? int'($urandom_range(len, 1)) : len + int'($urandom_range(4, 1));
            run_xfer($sformatf("test_random_%0d", k), base, len, nb, $urandom_range(2, 0));
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        cmd_valid   = 1'b0;
        cmd_base    = '0;
        cmd_len     = '0;
        abort       = 1'b0;
        tdata       = '0;
        tvalid      = 1'b0;
        tlast       = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_short();
        test_long();
        test_empty();
        test_abort(1'b0);
        test_abort(1'b1);
        test_reset_mid();
        test_random_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
